// File: rtl/frame_extender_pkg.sv
// ============================================================================
//  Module      : frame_extender_pkg
//  Description : Shared types and width helpers for the frame extender path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_extender_pkg;

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    // Pixel width rounded up to whole bytes for the AXI4-Stream tdata bus.
    function automatic int calc_tdata_width(input int px_width);
        return ((px_width + 7) / 8) * 8;
    endfunction

    // One extra bit so a pointer can hold FRAME_RES_X itself (saturation value).
    function automatic int calc_line_ptr_width(input int frame_res_x);
        return $clog2(frame_res_x) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_stream_if.sv
// ============================================================================
//  Module      : axi4_stream_if
//  Description : AXI4-Stream bundle with master/slave modports.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi4_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1
);

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
        output tready
    );

endinterface

`default_nettype wire

// File: rtl/line_buf_ram.sv
// ============================================================================
//  Module      : line_buf_ram
//  Description : Simple dual-port line buffer, one write port, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buf_ram #(
    parameter int DEPTH      = 1920,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  wire                    clk_i,
    input  wire                    i_wr_en,
    input  wire  [ADDR_WIDTH-1:0]  i_wr_addr,
    input  wire  [WIDTH-1:0]       i_wr_data,
    input  wire                    i_rd_en,
    input  wire  [ADDR_WIDTH-1:0]  i_rd_addr,
    output logic [WIDTH-1:0]       o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read data holds while i_rd_en is low, so it doubles as the replay output register.
    always_ff @(posedge clk_i) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/eof_line_replicator.sv
// ============================================================================
//  Module      : eof_line_replicator
//  Description : Pass-through video that replays the last line EXTRA_LINES
//                times after an end-of-frame beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eof_line_replicator
    import frame_extender_pkg::*;
#(
    parameter int FRAME_RES_X = 1920,
    parameter int PX_WIDTH    = 10,
    parameter int EXTRA_LINES = 2
) (
    input  wire           clk_i,
    input  wire           rst_n_i,
    input  wire           eof_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o
);

    localparam int TDATA_WIDTH    = calc_tdata_width(PX_WIDTH);
    localparam int LINE_PTR_WIDTH = calc_line_ptr_width(FRAME_RES_X);
    localparam int ADDR_WIDTH     = (LINE_PTR_WIDTH > 1) ? LINE_PTR_WIDTH - 1 : 1;
    localparam int REP_WIDTH      = (EXTRA_LINES > 1) ? $clog2(EXTRA_LINES + 1) : 1;

    localparam logic [LINE_PTR_WIDTH-1:0] c_RES_X     = LINE_PTR_WIDTH'(FRAME_RES_X);
    localparam logic [LINE_PTR_WIDTH-1:0] c_PTR_ONE   = LINE_PTR_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0]      c_EXTRA     = REP_WIDTH'(EXTRA_LINES);
    localparam logic [REP_WIDTH-1:0]      c_EXTRA_M1  = REP_WIDTH'(EXTRA_LINES - 1);
    localparam logic [REP_WIDTH-1:0]      c_REP_ONE   = REP_WIDTH'(1);

    state_t                    r_state;
    logic [LINE_PTR_WIDTH-1:0] r_wr_ptr;
    logic [LINE_PTR_WIDTH-1:0] r_rd_ptr;
    logic [LINE_PTR_WIDTH-1:0] r_line_len;
    logic [REP_WIDTH-1:0]      r_rep_cnt;
    logic                      r_out_valid;
    logic                      r_out_last;
    logic                      r_out_final;

    logic                      w_in_hs;
    logic                      w_out_hs;
    logic                      w_wr_en;
    logic                      w_rd_en;
    logic                      w_rd_last;
    logic [TDATA_WIDTH-1:0]    w_rd_data;

    assign w_in_hs   = video_i.tvalid && video_i.tready;
    assign w_out_hs  = video_o.tvalid && video_o.tready;
    assign w_wr_en   = w_in_hs && (r_wr_ptr < c_RES_X);
    assign w_rd_last = (r_rd_ptr == (r_line_len - c_PTR_ONE));

    // A new read is issued only while copies remain and the output slot frees up.
    assign w_rd_en   = (r_state == REPLAY) && (r_rep_cnt != c_EXTRA) &&
                       (!r_out_valid || w_out_hs);

    line_buf_ram #(
        .DEPTH      (FRAME_RES_X),
        .WIDTH      (TDATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line_buf_ram (
        .clk_i     (clk_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (video_i.tdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= PASS;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_line_len  <= '0;
            r_rep_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_final <= 1'b0;
        end else begin
            case (r_state)
                PASS: begin
                    if (w_in_hs) begin
                        if (video_i.tlast) begin
                            r_wr_ptr   <= '0;
                            r_line_len <= (r_wr_ptr == c_RES_X) ? c_RES_X : r_wr_ptr + c_PTR_ONE;
                            if (eof_i && (EXTRA_LINES > 0)) begin
                                r_state     <= REPLAY;
                                r_rd_ptr    <= '0;
                                r_rep_cnt   <= '0;
                                r_out_valid <= 1'b0;
                            end
                        end else if (r_wr_ptr != c_RES_X) begin
                            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                        end
                    end
                end
                REPLAY: begin
                    if (w_rd_en) begin
                        r_out_valid <= 1'b1;
                        r_out_last  <= w_rd_last;
                        r_out_final <= w_rd_last && (r_rep_cnt == c_EXTRA_M1);
                        if (w_rd_last) begin
                            r_rd_ptr  <= '0;
                            r_rep_cnt <= r_rep_cnt + c_REP_ONE;
                        end else begin
                            r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                        end
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        if (r_out_final) begin
                            r_state <= PASS;
                        end
                    end
                end
                default: r_state <= PASS;
            endcase
        end
    end

    assign video_i.tready = (r_state == PASS) && video_o.tready;

    always_comb begin
        video_o.tvalid = video_i.tvalid;
        video_o.tdata  = video_i.tdata;
        video_o.tstrb  = video_i.tstrb;
        video_o.tkeep  = video_i.tkeep;
        video_o.tlast  = video_i.tlast;
        video_o.tuser  = video_i.tuser;
        video_o.tid    = video_i.tid;
        video_o.tdest  = video_i.tdest;
        if (r_state == REPLAY) begin
            video_o.tvalid = r_out_valid;
            video_o.tdata  = w_rd_data;
            video_o.tstrb  = '1;
            video_o.tkeep  = '1;
            video_o.tlast  = r_out_last;
            video_o.tuser  = '0;
            video_o.tid    = '0;
            video_o.tdest  = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_eof_line_replicator.sv
// ============================================================================
//  Module      : tb_eof_line_replicator
//  Description : Scoreboard bench for eof_line_replicator with a line-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eof_line_replicator;
    import frame_extender_pkg::*;

    localparam int RES_X = 8;
    localparam int PXW   = 10;
    localparam int EXTRA = 2;
    localparam int TDW   = calc_tdata_width(PXW);

    typedef struct packed {
        logic [TDW-1:0] data;
        logic           last;
        logic           user;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic eof   = 1'b0;

    axi4_stream_if #(.DATA_WIDTH(TDW)) vin ();
    axi4_stream_if #(.DATA_WIDTH(TDW)) vout ();

    eof_line_replicator #(
        .FRAME_RES_X (RES_X),
        .PX_WIDTH    (PXW),
        .EXTRA_LINES (EXTRA)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .eof_i   (eof),
        .video_i (vin),
        .video_o (vout)
    );

    always #5 clk = ~clk;

    int             total = 0;
    int             bad   = 0;
    int             seen  = 0;
    int             low_cnt = 0;
    bit             rand_ready = 1'b0;
    beat_t          exp_q[$];
    logic [TDW-1:0] cur_line[$];
    logic [TDW-1:0] last_line[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: every accepted beat is forwarded; a tlast+eof beat appends
    // EXTRA copies of the first min(len, RES_X) pixels of that line.
    task automatic model_beat(input logic [TDW-1:0] d, input logic l, input logic u, input logic e);
        int n;
        exp_q.push_back('{data: d, last: l, user: u});
        cur_line.push_back(d);
        if (l) begin
            last_line = cur_line;
            cur_line.delete();
            if (e) begin
                n = (last_line.size() < RES_X) ? last_line.size() : RES_X;
                for (int r = 0; r < EXTRA; r++)
                    for (int i = 0; i < n; i++)
                        exp_q.push_back('{data: last_line[i], last: (i == n - 1), user: 1'b0});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            vin.tvalid = 1'b0;
            vin.tlast  = 1'($urandom_range(1, 0));
            eof        = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        vin.tlast = 1'b0;
        eof       = 1'b0;
    endtask

    task automatic send_beat(input logic [TDW-1:0] d, input logic l, input logic u, input logic e);
        int guard;
        model_beat(d, l, u, e);
        vin.tvalid = 1'b1;
        vin.tdata  = d;
        vin.tlast  = l;
        vin.tuser  = u;
        eof        = e;
        guard      = 0;
        forever begin
            @(negedge clk);
            if (vin.tready) break;
            guard++;
            if (guard > 500) begin
                total++;
                bad++;
                $display("FAIL send_timeout: tready=0 for %0d cycles, want handshake", guard);
                break;
            end
        end
        @(posedge clk);
        #1;
        vin.tvalid = 1'b0;
        vin.tlast  = 1'b0;
        vin.tuser  = 1'b0;
        eof        = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int base, input bit eof_end,
                              input bit gaps, input bit rnd_data);
        logic [TDW-1:0] d;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (gaps && ($urandom_range(3, 0) == 0)) idle($urandom_range(2, 1));
                d = rnd_data ? TDW'($urandom) : TDW'(base + y * w + x);
                send_beat(d, (x == w - 1), (x == 0 && y == 0),
                          (x == w - 1) ? (eof_end && y == h - 1) : 1'($urandom_range(3, 0) == 0));
            end
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        vout.tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    logic  pv, pr;
    logic [TDW+1:0] pbeat;
    beat_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(vout.tvalid), 32'd1);
                chk("hold_data", 32'({vout.tdata, vout.tlast, vout.tuser}), 32'(pbeat));
            end
            if (vout.tvalid && vout.tready) begin
                seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data=%0h last=%0b want none", vout.tdata, vout.tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", 32'(vout.tdata), 32'(mon_e.data));
                    chk("beat_last", 32'(vout.tlast), 32'(mon_e.last));
                    chk("beat_user", 32'(vout.tuser), 32'(mon_e.user));
                end
            end
            if (!vin.tready) low_cnt++;
            pv    = vout.tvalid;
            pr    = vout.tready;
            pbeat = {vout.tdata, vout.tlast, vout.tuser};
        end
    end

    initial begin
        int g;
        vin.tvalid  = 1'b0;
        vin.tdata   = '0;
        vin.tlast   = 1'b0;
        vin.tuser   = 1'b0;
        vin.tid     = 1'b0;
        vin.tdest   = 1'b0;
        vin.tstrb   = '1;
        vin.tkeep   = '1;
        vout.tready = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tvalid", 32'(vout.tvalid), 32'd0);
        chk("reset_tready", 32'(vin.tready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4x3 frame, full-rate sink
        seen = 0;
        low_cnt = 0;
        send_frame(4, 3, 0, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t1_beats", 32'(seen), 32'd20);
        chk("t1_ready_low", 32'(low_cnt), 32'd9);
        chk("t1_ready_back", 32'(vin.tready), 32'd1);

        // Same frame, random sink backpressure
        rand_ready = 1'b1;
        seen = 0;
        send_frame(4, 3, 0, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t2_beats", 32'(seen), 32'd20);

        // Back-to-back frames; second one waits out the replay
        seen = 0;
        send_frame(4, 3, 100, 1'b1, 1'b0, 1'b0);
        send_frame(3, 2, 200, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t3_beats", 32'(seen), 32'd32);

        // eof only on non-tlast beats and on idle tlast cycles: no replay
        seen = 0;
        send_frame(4, 2, 300, 1'b0, 1'b1, 1'b0);
        idle(4);
        wait_drain();
        chk("t4_beats", 32'(seen), 32'd8);

        // Over-long line: 11 beats forwarded, only the first 8 replayed
        seen = 0;
        send_frame(RES_X + 3, 1, 400, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t5_beats", 32'(seen), 32'd27);

        // Single-pixel lines
        send_frame(1, 2, 450, 1'b1, 1'b0, 1'b0);
        wait_drain();

        // Random frames
        for (int f = 0; f < 25; f++) begin
            send_frame($urandom_range(10, 1), $urandom_range(3, 1), 0,
                       1'($urandom_range(3, 0) != 0), 1'b1, 1'b1);
        end
        wait_drain();

        // Reset during the second replayed line
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        seen = 0;
        send_frame(4, 2, 500, 1'b1, 1'b0, 1'b0);
        g = 0;
        while (seen < 13 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("rst_reached", 32'(seen), 32'd13);
        #2;
        chk("rst_pre_tvalid", 32'(vout.tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(vout.tvalid), 32'd0);
        exp_q.delete();
        cur_line.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_tvalid", 32'(vout.tvalid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        send_frame(2, 2, 600, 1'b1, 1'b0, 1'b0);
        wait_drain();
        chk("t6_beats", 32'(seen), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
